key_event_gen: RTL

//  Sits downstream of the per-key debouncers in the Tetris input path.

---
 rtl/key_event_gen_if.sv | 18 +
 rtl/key_event_gen.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/key_event_gen_if.sv
// Key-event stream bundle between the typematic generator and the game logic.
// Latency: pure wiring, no storage.
// Backpressure: an event transfers on a clock edge where evt_valid & evt_ready.
//   evt_valid  event present on evt_key/evt_kind (master -> slave)
//   evt_ready  consumer can take the event       (slave -> master)
//   evt_key    index of the key that generated the event
//   evt_kind   00 press, 01 repeat, 10 release
interface key_event_gen_if #(
    parameter int KEY_W = 2
) ();
    logic             evt_valid;
    logic             evt_ready;
    logic [KEY_W-1:0] evt_key;
    logic [1:0]       evt_kind;

    modport master (output evt_valid, output evt_key, output evt_kind, input evt_ready);
    modport slave  (input evt_valid, input evt_key, input evt_kind, output evt_ready);
endinterface

// File: rtl/key_event_gen.sv
// Per-key typematic FSMs turning debounced active-low key levels into press/repeat/release events.
// Latency: key_n low sampled at edge E0 -> held_o after E1 -> event valid after E2 (idle output).
// Backpressure: one-entry output register holds until accepted; per-key pending flags
//   absorb stalls, repeats coalesce, a second press/release while pending is dropped (evt_drop_o).
// Ports:
//   clk, rst     single clock, synchronous active-high reset
//   key_n_i      debounced key levels, 0 = pressed
//   evt          event stream (master side of key_event_gen_if)
//   held_o       registered "key currently down" per key
//   evt_drop_o   one-cycle pulse when a press or release event was lost
module key_event_gen #(
    parameter int                REPEAT_CYC_DUMMY = 0,
    parameter int                N_KEYS      = 4,
    parameter int                KEY_W       = 2,
    parameter int                CNT_W       = 25,
    parameter int                DELAY_CYC   = 25000000,
    parameter int                REPEAT_CYC  = 5000000,
    parameter logic [N_KEYS-1:0] REPEAT_MASK = 4'b0111
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_n_i,
    key_event_gen_if.master   evt,
    output logic [N_KEYS-1:0] held_o,
    output logic              evt_drop_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT, ST_HOLD} st_e;

    localparam logic [1:0]       KIND_PRESS = 2'b00;
    localparam logic [1:0]       KIND_REP   = 2'b01;
    localparam logic [1:0]       KIND_REL   = 2'b10;
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST   = CNT_W'(REPEAT_CYC - 1);

    logic [N_KEYS-1:0] key_q;
    st_e               st_q  [N_KEYS];
    st_e               st_d  [N_KEYS];
    logic [CNT_W-1:0]  cnt_q [N_KEYS];
    logic [CNT_W-1:0]  cnt_d [N_KEYS];
    logic [N_KEYS-1:0] held_q;
    logic [N_KEYS-1:0] pend_press_q, pend_rep_q, pend_rel_q;
    logic [N_KEYS-1:0] pend_press_d, pend_rep_d, pend_rel_d;
    logic [N_KEYS-1:0] set_press, set_rep, set_rel, kill_rep;
    logic [N_KEYS-1:0] clr_press, clr_rep, clr_rel;
    logic [N_KEYS-1:0] sel_oh;
    logic              sel_vld;
    logic [KEY_W-1:0]  sel_key;
    logic [1:0]        sel_kind;
    logic              load;
    logic              drop_d;
    logic              evt_valid_q;
    logic [KEY_W-1:0]  evt_key_q;
    logic [1:0]        evt_kind_q;
    logic              drop_q;

    // Typematic next-state: a release seen in any active state wins over counting.
    always_comb begin
        set_press = '0;
        set_rep   = '0;
        set_rel   = '0;
        kill_rep  = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            if (st_q[i] == ST_IDLE) begin
                if (!key_q[i]) begin
                    st_d[i]      = REPEAT_MASK[i] ? ST_DELAY : ST_HOLD;
                    cnt_d[i]     = '0;
                    set_press[i] = 1'b1;
                end
            end else if (key_q[i]) begin
                st_d[i]     = ST_IDLE;
                cnt_d[i]    = '0;
                set_rel[i]  = 1'b1;
                kill_rep[i] = 1'b1;
            end else begin
                case (st_q[i])
                    ST_DELAY: begin
                        if (cnt_q[i] == DELAY_LAST) begin
                            st_d[i]    = ST_REPEAT;
                            cnt_d[i]   = '0;
                            set_rep[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if (cnt_q[i] == REP_LAST) begin
                            cnt_d[i]   = '0;
                            set_rep[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Fixed priority: lowest key index first; scanning downward lets the lowest hit win.
    always_comb begin
        sel_vld  = 1'b0;
        sel_key  = '0;
        sel_kind = KIND_PRESS;
        sel_oh   = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (pend_press_q[i] | pend_rel_q[i] | pend_rep_q[i]) begin
                sel_vld   = 1'b1;
                sel_key   = KEY_W'(i);
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
                // press before release so a short tap never reports out of order
                sel_kind  = pend_press_q[i] ? KIND_PRESS :
                            pend_rel_q[i]   ? KIND_REL   : KIND_REP;
            end
        end
    end

    assign load      = !evt_valid_q || evt.evt_ready;
    assign clr_press = load ? (sel_oh & pend_press_q) : '0;
    assign clr_rel   = load ? (sel_oh & ~pend_press_q & pend_rel_q) : '0;
    assign clr_rep   = load ? (sel_oh & ~pend_press_q & ~pend_rel_q & pend_rep_q) : '0;

    // A flag being loaded this edge is free again, so a same-kind event re-pends instead of dropping.
    assign pend_press_d = (pend_press_q & ~clr_press) | set_press;
    assign pend_rel_d   = (pend_rel_q & ~clr_rel) | set_rel;
    assign pend_rep_d   = (pend_rep_q & ~clr_rep & ~kill_rep) | set_rep;
    assign drop_d       = |((set_press & pend_press_q & ~clr_press) |
                            (set_rel & pend_rel_q & ~clr_rel));

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q        <= '1;
            held_q       <= '0;
            pend_press_q <= '0;
            pend_rep_q   <= '0;
            pend_rel_q   <= '0;
            evt_valid_q  <= 1'b0;
            evt_key_q    <= '0;
            evt_kind_q   <= KIND_PRESS;
            drop_q       <= 1'b0;
            for (int i = 0; i < N_KEYS; i++) begin
                st_q[i]  <= ST_IDLE;
                cnt_q[i] <= '0;
            end
        end else begin
            key_q        <= key_n_i;
            pend_press_q <= pend_press_d;
            pend_rep_q   <= pend_rep_d;
            pend_rel_q   <= pend_rel_d;
            drop_q       <= drop_d;
            for (int i = 0; i < N_KEYS; i++) begin
                st_q[i]   <= st_d[i];
                cnt_q[i]  <= cnt_d[i];
                held_q[i] <= (st_d[i] != ST_IDLE);
            end
            if (load) begin
                evt_valid_q <= sel_vld;
                if (sel_vld) begin
                    evt_key_q  <= sel_key;
                    evt_kind_q <= sel_kind;
                end
            end
        end
    end

    assign evt.evt_valid = evt_valid_q;
    assign evt.evt_key   = evt_key_q;
    assign evt.evt_kind  = evt_kind_q;
    assign held_o        = held_q;
    assign evt_drop_o    = drop_q;

endmodule
